// File: rtl/rbr_to_bin_conv_if.sv
// Handshake bundle for the RBR-to-binary converter: operand in, W+1 bit result out.
interface rbr_to_bin_conv_if #(
  parameter int W = 64
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] x;
  logic           out_valid;
  logic           out_ready;
  logic [W:0]     y;
  logic           y_zero;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, y_zero
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, y_zero
  );
endinterface

// File: rtl/rbr_to_bin_conv.sv
// Iterative RBR -> two's complement converter, CW digits per cycle, result after W/CW cycles.
// Result is held in DONE until out_ready; in_ready is combinational from out_ready there.
module rbr_to_bin_conv #(
  parameter int W  = 64,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  rbr_to_bin_conv_if.slave  bus
);

  localparam int NSTEPS = W / CW;
  localparam int SW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(NSTEPS - 1);

  if ((W % CW) != 0) begin : g_cw_check
    $error("rbr_to_bin_conv: W must be a multiple of CW");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [W-1:0]  p_q;
  logic [W-1:0]  n_q;
  logic          carry_q;
  logic [SW-1:0] step_q;
  logic [W:0]    y_q;
  logic          y_zero_q;
  logic          out_valid_q;

  logic [W-1:0]  p_d;
  logic [W-1:0]  n_d;
  logic [CW-1:0] p_chunk;
  logic [CW-1:0] n_chunk;
  logic [CW:0]   sum_d;
  logic [W:0]    y_d;
  logic          accept;

  // Split digits into positive / negative bit vectors; 01 and 10 land in neither.
  always_comb begin
    p_d = '0;
    n_d = '0;
    for (int i = 0; i < W; i++) begin
      p_d[i] = bus.x[2*i+1] & bus.x[2*i];
      n_d[i] = ~bus.x[2*i+1] & ~bus.x[2*i];
    end
  end

  // P - N computed as P + ~N + 1, one chunk per cycle with the carry rippling between chunks.
  always_comb begin
    p_chunk = p_q[int'(step_q)*CW +: CW];
    n_chunk = n_q[int'(step_q)*CW +: CW];
    sum_d   = {1'b0, p_chunk} + {1'b0, ~n_chunk} + {{CW{1'b0}}, carry_q};
    y_d     = y_q;
    y_d[int'(step_q)*CW +: CW] = sum_d[CW-1:0];
    y_d[W]  = ~sum_d[CW];
  end

  assign bus.in_ready  = arst_n & ((state_q == S_IDLE) |
                                   ((state_q == S_DONE) & bus.out_ready));
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.y_zero    = y_zero_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      n_q         <= '0;
      carry_q     <= 1'b1;
      step_q      <= '0;
      y_q         <= '0;
      y_zero_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            p_q     <= p_d;
            n_q     <= n_d;
            carry_q <= 1'b1;
            step_q  <= '0;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          carry_q <= sum_d[CW];
          if (step_q == LAST_STEP) begin
            y_q         <= y_d;
            y_zero_q    <= ~|y_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            y_q[int'(step_q)*CW +: CW] <= sum_d[CW-1:0];
            step_q <= step_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            // Back-to-back: the next operand is taken in the same cycle the result leaves.
            if (accept) begin
              p_q     <= p_d;
              n_q     <= n_d;
              carry_q <= 1'b1;
              step_q  <= '0;
              state_q <= S_CONV;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rbr_to_bin_conv.sv
// Bench for rbr_to_bin_conv: directed cases on W=8/CW=4, then random sweeps on W=64 with CW=16 and CW=64.
module tb_rbr_to_bin_conv;

  typedef logic [65:0] exp_t;  // {zero flag, y}

  logic clk;
  logic arst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[3][$];

  rbr_to_bin_conv_if #(.W(8))  b8();
  rbr_to_bin_conv_if #(.W(64)) b16();
  rbr_to_bin_conv_if #(.W(64)) b64();

  rbr_to_bin_conv #(.W(8),  .CW(4))  u8  (.clk(clk), .arst_n(arst_n), .bus(b8));
  rbr_to_bin_conv #(.W(64), .CW(16)) u16 (.clk(clk), .arst_n(arst_n), .bus(b16));
  rbr_to_bin_conv #(.W(64), .CW(64)) u64 (.clk(clk), .arst_n(arst_n), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Reference: sum of +/-2^i over digits in wide arithmetic, then wrapped to W+1 bits.
  function automatic exp_t ref_val(input logic [127:0] xv, input int w);
    logic [65:0] v;
    logic [64:0] mask;
    logic [1:0]  d;
    v = '0;
    for (int i = 0; i < w; i++) begin
      d = xv[2*i +: 2];
      if (d == 2'b11)      v = v + (66'd1 << i);
      else if (d == 2'b00) v = v - (66'd1 << i);
    end
    mask = (65'd1 << (w + 1)) - 65'd1;
    return {(v == 66'd0), v[64:0] & mask};
  endfunction

  task automatic put(input int id, input logic iv, input logic [127:0] xv, input logic orr);
    case (id)
      0:       begin b8.in_valid  = iv; b8.x  = xv[15:0]; b8.out_ready  = orr; end
      1:       begin b16.in_valid = iv; b16.x = xv;       b16.out_ready = orr; end
      default: begin b64.in_valid = iv; b64.x = xv;       b64.out_ready = orr; end
    endcase
  endtask

  function automatic logic get_iv(input int id);
    return (id == 0) ? b8.in_valid : (id == 1) ? b16.in_valid : b64.in_valid;
  endfunction
  function automatic logic get_ir(input int id);
    return (id == 0) ? b8.in_ready : (id == 1) ? b16.in_ready : b64.in_ready;
  endfunction
  function automatic logic get_ov(input int id);
    return (id == 0) ? b8.out_valid : (id == 1) ? b16.out_valid : b64.out_valid;
  endfunction
  function automatic logic get_or(input int id);
    return (id == 0) ? b8.out_ready : (id == 1) ? b16.out_ready : b64.out_ready;
  endfunction
  function automatic logic get_z(input int id);
    return (id == 0) ? b8.y_zero : (id == 1) ? b16.y_zero : b64.y_zero;
  endfunction
  function automatic logic [64:0] get_y(input int id);
    return (id == 0) ? 65'(b8.y) : (id == 1) ? b16.y : b64.y;
  endfunction
  function automatic logic [127:0] get_x(input int id);
    return (id == 0) ? 128'(b8.x) : (id == 1) ? b16.x : b64.x;
  endfunction
  function automatic int width_of(input int id);
    return (id == 0) ? 8 : 64;
  endfunction

  // Compare process: every cycle a result is presented it must match the oldest accepted operand.
  task automatic mon(input int id);
    exp_t e;
    if (get_ov(id)) begin
      if (sb[id].size() == 0) begin
        check($sformatf("sb%0d_spurious_out_valid", id), 65'd1, 65'd0);
      end else begin
        e = sb[id][0];
        check($sformatf("sb%0d_y", id), get_y(id), e[64:0]);
        check($sformatf("sb%0d_zero", id), 65'(get_z(id)), 65'(e[65]));
        if (get_or(id)) void'(sb[id].pop_front());
      end
    end
    if (get_iv(id) && get_ir(id)) sb[id].push_back(ref_val(get_x(id), width_of(id)));
  endtask

  always @(negedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < 3; i++) sb[i].delete();
    end else begin
      for (int i = 0; i < 3; i++) mon(i);
    end
  end

  function automatic logic [127:0] rand_x();
    logic [127:0] r;
    int mode;
    mode = $urandom_range(0, 7);
    for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
    if (mode == 0) begin
      for (int i = 0; i < 64; i++) r[2*i +: 2] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    end else if (mode == 1) begin
      r = '1;
    end else if (mode == 2) begin
      r = '0;
    end
    return r;
  endfunction

  task automatic start(input int id, input logic [127:0] xv, input string nm);
    put(id, 1'b1, xv, 1'b0);
    #1;
    check({nm, "_in_ready"}, 65'(get_ir(id)), 65'd1);
    @(posedge clk); #1;
    put(id, 1'b0, rand_x(), 1'b0);
  endtask

  // Called 1 time unit after the accept edge: out_valid must rise exactly ns edges later.
  task automatic expect_res(input int id, input int ns, input logic [64:0] ey, input logic ez,
                            input string nm);
    for (int k = 0; k < ns; k++) begin
      check($sformatf("%s_busy%0d", nm, k), 65'(get_ov(id)), 65'd0);
      @(posedge clk); #1;
    end
    check({nm, "_out_valid"}, 65'(get_ov(id)), 65'd1);
    check({nm, "_y"}, get_y(id), ey);
    check({nm, "_y_zero"}, 65'(get_z(id)), 65'(ez));
  endtask

  task automatic drain(input int id);
    put(id, 1'b0, rand_x(), 1'b1);
    @(posedge clk); #1;
    put(id, 1'b0, rand_x(), 1'b0);
  endtask

  task automatic run8(input logic [15:0] xv, input logic [8:0] ey, input logic ez, input string nm);
    start(0, 128'(xv), nm);
    expect_res(0, 2, 65'(ey), ez, nm);
    drain(0);
  endtask

  task automatic rnd_drive(input int id, input int n);
    int sent = 0;
    int cyc = 0;
    logic iv = 1'b0;
    logic acc;
    logic [127:0] xv = '0;
    while (sent < n && cyc < 60000) begin
      @(negedge clk);
      acc = iv && get_ir(id);
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        iv = 1'b0;
      end
      if (!iv && sent < n && $urandom_range(0, 3) != 0) begin
        iv = 1'b1;
        xv = rand_x();
      end
      put(id, iv, xv, $urandom_range(0, 9) < 7);
    end
    check($sformatf("rnd%0d_sent", id), 65'(sent), 65'(n));
    put(id, 1'b0, xv, 1'b1);
    for (int k = 0; k < 50 && (sb[id].size() != 0 || get_ov(id)); k++) begin
      @(posedge clk); #1;
    end
    check($sformatf("rnd%0d_pending", id), 65'(sb[id].size()), 65'd0);
    put(id, 1'b0, xv, 1'b0);
  endtask

  initial begin
    arst_n = 1'b0;
    for (int i = 0; i < 3; i++) put(i, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d_out_valid", i), 65'(get_ov(i)), 65'd0);
      check($sformatf("rst%0d_y", i), get_y(i), 65'd0);
      check($sformatf("rst%0d_y_zero", i), 65'(get_z(i)), 65'd0);
    end
    arst_n = 1'b1;
    @(posedge clk); #1;

    run8(16'hFFFF, 9'h0FF, 1'b0, "all_plus");
    run8(16'h0000, 9'h101, 1'b0, "all_minus");
    run8(16'h5555, 9'h000, 1'b1, "zero_01");
    run8(16'hAAAA, 9'h000, 1'b1, "zero_10");
    run8(16'h6969, 9'h000, 1'b1, "zero_mixed");
    // digit7=+1, others 0 -> 128; digit7=+1, digit0=-1 -> 127
    run8(16'hD555, 9'h080, 1'b0, "d7_plus");
    run8(16'hD554, 9'h07F, 1'b0, "d7_plus_d0_minus");
    // digit7=+1 with digits 6..1 = -1 -> 2, and with digits 6..0 = -1 -> 1
    run8(16'hC001, 9'h002, 1'b0, "c001");
    run8(16'hC000, 9'h001, 1'b0, "c000");
    // three encodings of +1
    run8(16'h5557, 9'h001, 1'b0, "one_a");
    run8(16'h555C, 9'h001, 1'b0, "one_b");
    run8(16'hAAAB, 9'h001, 1'b0, "one_c");

    // Back-pressure: result held, operand changes ignored, then hand-over in one cycle.
    start(0, 128'(16'h7555), "bp");
    expect_res(0, 2, 65'h040, 1'b0, "bp");
    for (int k = 0; k < 5; k++) begin
      put(0, 1'b1, rand_x(), 1'b0);
      @(posedge clk); #1;
      check($sformatf("bp_stall%0d_in_ready", k), 65'(b8.in_ready), 65'd0);
      check($sformatf("bp_stall%0d_out_valid", k), 65'(b8.out_valid), 65'd1);
      check($sformatf("bp_stall%0d_y", k), 65'(b8.y), 65'h040);
    end
    put(0, 1'b1, 128'(16'hFFFC), 1'b1);
    #1;
    check("bp_handover_in_ready", 65'(b8.in_ready), 65'd1);
    @(posedge clk); #1;
    put(0, 1'b0, rand_x(), 1'b0);
    expect_res(0, 2, 65'h0FD, 1'b0, "bp_next");
    drain(0);

    // Reset in the first CONV cycle drops the operation.
    start(0, 128'(16'h0000), "rst_mid");
    arst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 65'(b8.out_valid), 65'd0);
    check("rst_mid_y", 65'(b8.y), 65'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst_mid_quiet%0d", k), 65'(b8.out_valid), 65'd0);
    end
    run8(16'hFFFF, 9'h0FF, 1'b0, "after_rst");

    // Latency on the wide instances: 4 steps for CW=16, single step when W==CW.
    start(1, '0, "w64c16");
    expect_res(1, 4, {1'b1, 64'h0000_0000_0000_0001}, 1'b0, "w64c16");
    drain(1);
    start(2, '1, "w64c64");
    expect_res(2, 1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, "w64c64");
    drain(2);

    fork
      rnd_drive(1, 5000);
      rnd_drive(2, 5000);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
